multi_alu_seq: RTL and testbench
================================

# multi_alu_seq

Sequencer that owns a 128-bit AES state (four 32-bit words) and streams it, one word per cycle, through a single shared Multi_Alu instance. It issues the operand, second operand and select code for each word, then writes the result back. It supports AddRoundKey, MixColumns, byte-rotate (ShiftRows on row-stored data) and a fused MixColumns+AddRoundKey round. It sits between the SIMD control unit (start/op/done handshake) and the Multi_Alu datapath, which is instantiated outside this block.

## Interface
- SEL_XOR, 3'b011: Multi_Alu select code for bytewise XOR.
- SEL_ROT, 3'b100: Multi_Alu select code for rotate-left by b*8 bits.
- SEL_MIX, 3'b101: Multi_Alu select code for GF(2^8) MixColumns of a word.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  write state_in into state (accepted in IDLE only)
- state_in  in  128  word i = state_in[32i+31:32i]
- start  in  1  begin operation (accepted in IDLE only)
- op  in  2  0=ADDKEY, 1=MIX, 2=ROT, 3=ROUND (MIX then ADDKEY)
- key_in  in  128  round key, latched on accepted start
- alu_a  out  32  Multi_Alu input a
- alu_b  out  32  Multi_Alu input b
- alu_sel  out  3  Multi_Alu select
- alu_result  in  32  Multi_Alu result_alu (combinational)
- state_out  out  128  current state register, same word order
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle pulse when the operation completes

## Operation
- FSM states are IDLE, RUN and DONE. Counters are `cnt` (2 bits, word index) and `phase` (1 bit, used by ROUND only).
- IDLE:
  - load=1 writes state <= state_in.
  - start=1 latches op and key_in, clears cnt and phase, and moves to RUN.
  - If load and start arrive together, both are accepted. The loaded data is what gets processed.
- RUN drives alu_a = state[cnt] every cycle. The other ALU inputs depend on the effective op:
  - ADDKEY: alu_b = key[cnt], alu_sel = SEL_XOR.
  - MIX: alu_b = 0, alu_sel = SEL_MIX.
  - ROT: alu_b = {30'b0, cnt}, alu_sel = SEL_ROT. Word i rotates left by i bytes; word 0 is unchanged.
  - ROUND: behaves as MIX while phase=0 and as ADDKEY while phase=1.
- RUN write-back and exit:
  - Every RUN edge: state[cnt] <= alu_result, then cnt <= cnt+1 (wraps 3 to 0).
  - At cnt=3: ROUND with phase=0 sets phase to 1 and stays in RUN. All other cases go to DONE.
- DONE: done=1 for one cycle, then unconditionally return to IDLE.
- start and load are ignored outside IDLE. Changes on key_in or state_in during RUN have no effect.
- In IDLE and DONE, alu_a, alu_b and alu_sel are all 0.

## Timing
- Reset (async, rst_n=0) clears state to 0, clears cnt, phase, op and key, and puts the FSM in IDLE. During reset, busy, done, alu_a, alu_b and alu_sel are all 0 and state_out=0.
- Reset asserted mid-RUN aborts immediately. Partially written words are lost (state is 0) and no done pulse is issued.
- Latency, with start accepted at edge 0:
  - ADDKEY, MIX and ROT use RUN for cycles 1–4 and pulse done in cycle 5. state_out holds the final value from cycle 5.
  - ROUND uses RUN for cycles 1–8 and pulses done in cycle 9.
- busy rises the cycle after the accepted start and falls the cycle after done.
- The earliest back-to-back start is the cycle after done, when the FSM is back in IDLE. A start held high continuously therefore re-triggers every 6 cycles for single-phase ops.
- alu_result is sampled on the same edge that advances cnt. The Multi_Alu path must meet a single-cycle combinational timing budget.
- All outputs come from registers except alu_a, alu_b and alu_sel. Those are decoded from registered FSM/cnt/state only, with no input-to-output combinational path.

## Test plan
- **Reset:** assert rst_n=0 mid-RUN of a MIX. Required: state_out=0, busy=0 and alu_sel=0 immediately; no done pulse; after release, IDLE accepts a new start.
- **MIX:** load word0=32'hdb135345, word1=32'hf20a225c, words 2–3=32'h01010101, then start op=1. Required: after 5 cycles, done pulses and the words are 32'h8e4da1bc, 32'h9fdc589d and 32'h01010101 (×2).
- **ROT:** load words 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, then start op=2. Required: result 32'h00112233, 32'h55667744, 32'haabb8899, 32'hffccddee; done in cycle 5.
- **ADDKEY:** load all words 32'hffffffff, key words 32'h0, 32'h1, 32'h2, 32'h3. Required: state 32'hffffffff, 32'hfffffffe, 32'hfffffffd, 32'hfffffffc.
- **ROUND:** MIX vector above with key words all 32'h00000001. Required: 8 RUN cycles, done in cycle 9, word0=32'h8e4da1bd. Also, key_in changed during RUN has no effect.
- **Handshake edges:** load+start in the same cycle processes the new data. start during busy is ignored, shown by an unchanged op. A held start restarts exactly one cycle after done.

Source files
------------

// File: rtl/multi_alu_seq.sv
// Sequencer that streams a 128-bit AES state word-by-word through an external Multi_Alu
// and writes each result back, for AddRoundKey, MixColumns, byte-rotate and fused rounds.
module multi_alu_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] state_in,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [127:0] key_in,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    output logic [2:0]   alu_sel,
    input  logic [31:0]  alu_result,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned N_WORDS = 4;

    localparam logic [1:0] OP_ADDKEY = 2'd0;
    localparam logic [1:0] OP_MIX    = 2'd1;
    localparam logic [1:0] OP_ROT    = 2'd2;
    localparam logic [1:0] OP_ROUND  = 2'd3;

    localparam logic [2:0] SEL_XOR = 3'b011;
    localparam logic [2:0] SEL_ROT = 3'b100;
    localparam logic [2:0] SEL_MIX = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t                            fsm_q, fsm_d;
    logic [1:0]                      cnt_q;
    logic                            phase_q;
    logic [1:0]                      op_q;
    logic [1:0]                      eff_op;
    logic [N_WORDS-1:0][WORD_W-1:0]  st_q;
    logic [N_WORDS-1:0][WORD_W-1:0]  key_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state and ALU operand decode; ROUND runs a MIX pass then an ADDKEY pass
    always_comb begin
        fsm_d   = fsm_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        eff_op  = op_q;
        if (op_q == OP_ROUND) begin
            eff_op = phase_q ? OP_ADDKEY : OP_MIX;
        end
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    fsm_d = S_RUN;
                end
            end
            S_RUN: begin
                alu_a = st_q[cnt_q];
                case (eff_op)
                    OP_ADDKEY: begin
                        alu_b   = key_q[cnt_q];
                        alu_sel = SEL_XOR;
                    end
                    OP_MIX: begin
                        alu_sel = SEL_MIX;
                    end
                    OP_ROT: begin
                        alu_b   = WORD_W'(cnt_q);
                        alu_sel = SEL_ROT;
                    end
                    default: ;
                endcase
                if (cnt_q == 2'd3 && !(op_q == OP_ROUND && !phase_q)) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // Datapath: state/key/op capture, per-word write-back, registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            op_q    <= '0;
            key_q   <= '0;
            st_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (fsm_d != S_IDLE);
            done <= (fsm_d == S_DONE);
            case (fsm_q)
                S_IDLE: begin
                    if (load) begin
                        st_q <= state_in;
                    end
                    if (start) begin
                        op_q    <= op;
                        key_q   <= key_in;
                        cnt_q   <= '0;
                        phase_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    st_q[cnt_q] <= alu_result;
                    cnt_q       <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        phase_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_out = st_q;

endmodule

// File: tb/tb_multi_alu_seq.sv
// Scoreboard bench for multi_alu_seq with a behavioural Multi_Alu driving alu_result.
module tb_multi_alu_seq;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [127:0] state_in;
    logic         start;
    logic [1:0]   op;
    logic [127:0] key_in;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [2:0]   alu_sel;
    logic [31:0]  alu_result;
    logic [127:0] state_out;
    logic         busy;
    logic         done;

    typedef struct {
        string        name;
        logic [127:0] st;
        int           lat;
        int           start_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    multi_alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .state_in   (state_in),
        .start      (start),
        .op         (op),
        .key_in     (key_in),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .state_out  (state_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Behavioural Multi_Alu; byte 0 of a column is the most significant byte
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] sel);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24]; a1 = a[23:16]; a2 = a[15:8]; a3 = a[7:0];
        case (sel)
            3'b011: return a ^ b;
            3'b100: begin
                case (b[1:0])
                    2'd0: return a;
                    2'd1: return {a[23:0], a[31:24]};
                    2'd2: return {a[15:0], a[31:16]};
                    default: return {a[7:0], a[31:8]};
                endcase
            end
            3'b101: return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_sel);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result and checks data and latency
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                int   lat;
                e   = sb_q.pop_front();
                lat = cyc - e.start_cyc + 1;
                chk({e.name, "_state"}, state_out, e.st);
                chk({e.name, "_done_cycle"}, 128'(unsigned'(lat)), 128'(unsigned'(e.lat)));
            end
        end
    end

    task automatic push_exp(input string nm, input logic [127:0] st, input int lat, input int sc);
        exp_t e;
        e.name = nm; e.st = st; e.lat = lat; e.start_cyc = sc;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=pending required=done", nm);
            sb_q.delete();
        end
        @(negedge clk);
        chk({nm, "_busy_fall"}, 128'(busy), 128'(1'b0));
    endtask

    // One operation; junk on load/start/op/key/state_in while busy must be ignored
    task automatic run_op(input string nm, input logic same, input logic [127:0] din,
                          input logic [1:0] opc, input logic [127:0] key,
                          input logic [127:0] exp_st, input int exp_lat);
        int e;
        @(negedge clk);
        load = 1'b1;
        state_in = din;
        if (!same) begin
            @(negedge clk);
            load = 1'b0;
            state_in = ~din;
        end
        start = 1'b1; op = opc; key_in = key;
        @(posedge clk);
        #1;
        e = cyc;
        push_exp(nm, exp_st, exp_lat, e);
        chk({nm, "_busy_rise"}, 128'(busy), 128'(1'b1));
        @(negedge clk);
        load = 1'b1; state_in = ~din; key_in = ~key; start = 1'b1; op = opc + 2'd1;
        @(negedge clk);
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        wait_drain(nm);
    endtask

    localparam logic [127:0] MIX_IN  = {32'h01010101, 32'h01010101, 32'hf20a225c, 32'hdb135345};
    localparam logic [127:0] MIX_OUT = {32'h01010101, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc};
    localparam logic [127:0] ROT_IN  = {32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
    localparam logic [127:0] ROT_OUT = {32'hffccddee, 32'haabb8899, 32'h55667744, 32'h00112233};
    localparam logic [127:0] ROT2    = {32'heeffccdd, 32'h8899aabb, 32'h66774455, 32'h00112233};
    localparam logic [127:0] ONES    = {4{32'hffffffff}};
    localparam logic [127:0] KEY_IDX = {32'h3, 32'h2, 32'h1, 32'h0};
    localparam logic [127:0] ADD_OUT = {32'hfffffffc, 32'hfffffffd, 32'hfffffffe, 32'hffffffff};
    localparam logic [127:0] KEY_ONE = {4{32'h00000001}};
    localparam logic [127:0] RND_OUT = {32'h01010100, 32'h01010100, 32'h9fdc589c, 32'h8e4da1bd};

    initial begin
        int e;
        int seen;
        rst_n = 1'b0; load = 1'b0; start = 1'b0; op = 2'd0;
        state_in = '0; key_in = '0;
        #1;
        chk("reset_state_out", state_out, 128'h0);
        chk("reset_busy", 128'(busy), 128'(1'b0));
        chk("reset_done", 128'(done), 128'(1'b0));
        chk("reset_alu", 128'({alu_a, alu_b, alu_sel}), 128'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op("mix", 1'b0, MIX_IN, 2'd1, '0, MIX_OUT, 5);
        run_op("rot", 1'b1, ROT_IN, 2'd2, '0, ROT_OUT, 5);
        run_op("addkey", 1'b0, ONES, 2'd0, KEY_IDX, ADD_OUT, 5);
        run_op("round", 1'b0, MIX_IN, 2'd3, KEY_ONE, RND_OUT, 9);
        chk("idle_alu_zero", 128'({alu_a, alu_b, alu_sel}), 128'h0);

        // Held start: second ROT accepted six edges after the first
        @(negedge clk);
        load = 1'b1; state_in = ROT_IN; start = 1'b1; op = 2'd2; key_in = '0;
        @(posedge clk);
        #1;
        e = cyc;
        load = 1'b0;
        push_exp("held1", ROT_OUT, 5, e);
        push_exp("held2", ROT2, 5, e + 6);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain("held");

        // Reset in the middle of a MIX aborts with no done pulse
        @(negedge clk);
        load = 1'b1; state_in = MIX_IN; start = 1'b1; op = 2'd1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_state_out", state_out, 128'h0);
        chk("abort_busy", 128'(busy), 128'(1'b0));
        chk("abort_alu_sel", 128'(alu_sel), 128'h0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("abort_no_done", 128'(unsigned'(seen)), 128'h0);
        rst_n = 1'b1;
        run_op("post_reset_addkey", 1'b0, ONES, 2'd0, KEY_IDX, ADD_OUT, 5);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
